// File: rtl/rep_seq_pkg.sv
// Shared types for the REP string-op sequencer.
// State, rep-mode and operand-size encodings plus the size-to-step helper.
package rep_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAITZ,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    REP_PLAIN = 2'b00,
    REP_E     = 2'b01,
    REP_NE    = 2'b10,
    REP_RSVD  = 2'b11
  } rep_mode_e;

  typedef enum logic [1:0] {
    OP_B = 2'b00,
    OP_W = 2'b01,
    OP_D = 2'b10,
    OP_Q = 2'b11
  } opsize_e;

  function automatic logic [3:0] step_of(input opsize_e os);
    return 4'(1) << os;
  endfunction

endpackage

// File: rtl/rep_addr_chan.sv
// One string-op address channel: load, hold, or step up/down by delta.
// addr_nxt_o exposes the value the register takes at the next edge.
module rep_addr_chan #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] delta_i,
  output logic [W-1:0] addr_o,
  output logic [W-1:0] addr_nxt_o
);

  logic [W-1:0] addr_q;
  logic [W-1:0] sum;

  assign sum = dec_i ? addr_q - delta_i
                     : addr_q + delta_i;

  assign addr_nxt_o = step_i ? sum : addr_q;
  assign addr_o     = addr_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= load_val_i;
    end else begin
      addr_q <= addr_nxt_o;
    end
  end

endmodule

// File: rtl/rep_seq_unit.sv
// REP/REPE/REPNE sequencer for the M stage: one iteration per cycle,
// per-channel address stepping, ZF-driven early exit, upstream stall.
module rep_seq_unit
  import rep_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned NUM_CH     = 2
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         valid_in,
  input  logic                         is_rep_in,
  input  logic [1:0]                   rep_mode,
  input  logic                         df_in,
  input  logic [1:0]                   opsize_in,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [CNT_WIDTH-1:0]         cnt_in,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
  input  logic                         downstream_stall,
  input  logic                         zf_in,
  input  logic                         zf_valid,
  output logic                         iter_valid,
  output logic [NUM_CH*ADDR_WIDTH-1:0] addr_out,
  output logic [CNT_WIDTH-1:0]         cnt_out,
  output logic                         stall_up,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         cnt_final,
  output logic [NUM_CH*ADDR_WIDTH-1:0] addr_final
);

  state_e                       state_q;
  rep_mode_e                    mode_q;
  logic                         rep_q;
  logic                         df_q;
  logic [NUM_CH-1:0]            en_q;
  logic [ADDR_WIDTH-1:0]        step_q;
  logic [CNT_WIDTH-1:0]         cnt_q;
  logic [CNT_WIDTH-1:0]         fin_cnt_q;
  logic [NUM_CH*ADDR_WIDTH-1:0] fin_addr_q;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_q;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr_nxt;

  logic                 accept;
  logic                 adv;
  logic                 chk_zf;
  logic                 zf_term;
  logic [CNT_WIDTH-1:0] cnt_eff;
  logic [CNT_WIDTH-1:0] cnt_m1;

  assign accept  = (state_q == S_IDLE) && valid_in;
  assign adv     = (state_q == S_RUN) && !downstream_stall;
  assign cnt_eff = is_rep_in ? cnt_in : CNT_WIDTH'(1);
  assign cnt_m1  = cnt_q - CNT_WIDTH'(1);
  assign chk_zf  = rep_q && ((mode_q == REP_E) || (mode_q == REP_NE));
  assign zf_term = ((mode_q == REP_E) && !zf_in) ||
                   ((mode_q == REP_NE) && zf_in);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rep_addr_chan #(
      .W(ADDR_WIDTH)
    ) u_chan (
      .clk_i     (clk),
      .clr_ni    (clr),
      .load_i    (accept),
      .step_i    (adv & en_q[c]),
      .dec_i     (df_q),
      .load_val_i(addr_in[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .delta_i   (step_q),
      .addr_o    (addr_q[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .addr_nxt_o(addr_nxt[c*ADDR_WIDTH +: ADDR_WIDTH])
    );
  end

  // Final registers are captured on the edge that enters DONE,
  // so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      mode_q     <= REP_PLAIN;
      rep_q      <= 1'b0;
      df_q       <= 1'b0;
      en_q       <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      fin_cnt_q  <= '0;
      fin_addr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            mode_q <= rep_mode_e'(rep_mode);
            rep_q  <= is_rep_in;
            df_q   <= df_in;
            en_q   <= ch_en;
            step_q <= ADDR_WIDTH'(step_of(opsize_e'(opsize_in)));
            cnt_q  <= cnt_eff;
            if (cnt_eff == '0) begin
              state_q    <= S_DONE;
              fin_cnt_q  <= '0;
              fin_addr_q <= addr_in;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!downstream_stall) begin
            cnt_q <= cnt_m1;
            if (cnt_m1 == '0) begin
              state_q    <= S_DONE;
              fin_cnt_q  <= '0;
              fin_addr_q <= addr_nxt;
            end else if (chk_zf) begin
              state_q <= S_WAITZ;
            end
          end
        end
        S_WAITZ: begin
          if (zf_valid) begin
            if (zf_term) begin
              state_q    <= S_DONE;
              fin_cnt_q  <= cnt_q;
              fin_addr_q <= addr_q;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign iter_valid = (state_q == S_RUN);
  assign stall_up   = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_out   = addr_q;
  assign cnt_out    = cnt_q;
  assign cnt_final  = fin_cnt_q;
  assign addr_final = fin_addr_q;

endmodule

// File: tb/tb_rep_seq_unit.sv
// Self-checking bench for rep_seq_unit: directed scenarios plus random ops
// compared against an arithmetic model of the REP iteration rules.
module tb_rep_seq_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        valid_in;
  logic        is_rep_in;
  logic [1:0]  rep_mode;
  logic        df_in;
  logic [1:0]  opsize_in;
  logic [1:0]  ch_en;
  logic [31:0] cnt_in;
  logic [63:0] addr_in;
  logic        downstream_stall;
  logic        zf_in;
  logic        zf_valid;
  logic        iter_valid;
  logic [63:0] addr_out;
  logic [31:0] cnt_out;
  logic        stall_up;
  logic        done;
  logic [31:0] cnt_final;
  logic [63:0] addr_final;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rep_seq_unit #(
    .ADDR_WIDTH(32),
    .CNT_WIDTH (32),
    .NUM_CH    (2)
  ) dut (
    .clk             (clk),
    .clr             (clr),
    .valid_in        (valid_in),
    .is_rep_in       (is_rep_in),
    .rep_mode        (rep_mode),
    .df_in           (df_in),
    .opsize_in       (opsize_in),
    .ch_en           (ch_en),
    .cnt_in          (cnt_in),
    .addr_in         (addr_in),
    .downstream_stall(downstream_stall),
    .zf_in           (zf_in),
    .zf_valid        (zf_valid),
    .iter_valid      (iter_valid),
    .addr_out        (addr_out),
    .cnt_out         (cnt_out),
    .stall_up        (stall_up),
    .done            (done),
    .cnt_final       (cnt_final),
    .addr_final      (addr_final)
  );

  // Address of element i: base moved i elements in the DF direction.
  function automatic logic [31:0] ea(input logic [31:0] b, input bit e,
                                     input bit d, input logic [1:0] os,
                                     input int i);
    logic [31:0] off;
    off = 32'(i) * (32'd1 << os);
    if (!e) return b;
    return d ? b - off : b + off;
  endfunction

  task automatic run_op(input bit rep, input logic [1:0] mode,
                        input bit df, input logic [1:0] os,
                        input logic [1:0] en, input logic [31:0] cnt,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [63:0] zfs, input int st_iter,
                        input int st_len, input bit rnd,
                        output int done_cyc);
    int n, stop, k, cyc, st_used;
    bit st, fin;
    logic [63:0] ex;
    n = rep ? int'(cnt) : 1;
    stop = n;
    for (int i = 0; i < n - 1; i++) begin
      if (rep && ((mode == 2'b01 && !zfs[i]) || (mode == 2'b10 && zfs[i]))) begin
        stop = i + 1;
        break;
      end
    end
    @(negedge clk);
    valid_in = 1'b1; is_rep_in = rep; rep_mode = mode; df_in = df;
    opsize_in = os; ch_en = en; cnt_in = cnt; addr_in = {a1, a0};
    k = 0; cyc = 0; st_used = 0; fin = 0; done_cyc = -1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      valid_in = rnd ? 1'($urandom) : 1'b0;
      st = (k == st_iter && st_used < st_len) || (rnd && $urandom_range(0, 3) == 0);
      downstream_stall = st;
      zf_valid = rnd ? 1'($urandom) : 1'b0;
      zf_in = 1'($urandom);
      if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL timeout got=no_done cyc=%0d", cyc);
        fin = 1;
      end else if (done) begin
        ex = {ea(a1, en[1], df, os, stop), ea(a0, en[0], df, os, stop)};
        checks += 4;
        if (k != stop) begin
          errors++; $display("FAIL iters got=%0d exp=%0d", k, stop);
        end
        if (cnt_final !== 32'(n - stop)) begin
          errors++; $display("FAIL cnt_final got=%h exp=%h", cnt_final, 32'(n - stop));
        end
        if (addr_final !== ex) begin
          errors++; $display("FAIL addr_final got=%h exp=%h", addr_final, ex);
        end
        if (stall_up !== 1'b1 || iter_valid !== 1'b0) begin
          errors++; $display("FAIL done_flags got=%b%b exp=10", stall_up, iter_valid);
        end
        done_cyc = cyc;
        @(negedge clk);
        valid_in = 1'b0; downstream_stall = 1'b0; zf_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || stall_up !== 1'b0 || cnt_final !== 32'(n - stop) || addr_final !== ex) begin
          errors++;
          $display("FAIL post_done got=%b%b %h %h exp=00 %h %h",
                   done, stall_up, cnt_final, addr_final, 32'(n - stop), ex);
        end
        fin = 1;
      end else if (iter_valid) begin
        ex = {ea(a1, en[1], df, os, k), ea(a0, en[0], df, os, k)};
        checks++;
        if (k >= stop || addr_out !== ex || cnt_out !== 32'(n - k)) begin
          errors++;
          $display("FAIL iter%0d got=%h/%h exp=%h/%h", k, addr_out, cnt_out, ex, 32'(n - k));
        end
        if (st) st_used++;
        else k++;
      end else if (stall_up) begin
        zf_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        zf_in = (k > 0) ? zfs[k-1] : 1'b0;
      end else begin
        checks++; errors++;
        $display("FAIL early_idle got=idle exp=busy k=%0d", k);
        fin = 1;
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b0; valid_in = 1'b1; cnt_in = 32'd4; addr_in = 64'h55;
    repeat (2) @(negedge clk);
    checks++;
    if ({iter_valid, stall_up, done, addr_out, cnt_out, cnt_final, addr_final} !== '0) begin
      errors++; $display("FAIL reset_outs got=nonzero exp=0");
    end
    valid_in = 1'b0; clr = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_up !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle got=%b%b exp=00", stall_up, done);
    end
  endtask

  task automatic test_rep_basic;
    int d;
    run_op(1, 2'b00, 0, 2'b00, 2'b11, 32'd3, 32'h1000, 32'h2000, '0, -1, 0, 0, d);
    checks++;
    if (addr_final !== {32'h2003, 32'h1003} || d != 4) begin
      errors++; $display("FAIL basic_final got=%h cyc=%0d exp=%h cyc=4", addr_final, d, {32'h2003, 32'h1003});
    end
  endtask

  task automatic test_df_dec;
    int d;
    run_op(1, 2'b00, 1, 2'b10, 2'b01, 32'd2, 32'h100, 32'h500, '0, -1, 0, 0, d);
    checks++;
    if (addr_final !== {32'h500, 32'hF8}) begin
      errors++; $display("FAIL dec_final got=%h exp=%h", addr_final, {32'h500, 32'hF8});
    end
  endtask

  task automatic test_zero_count;
    int d;
    run_op(1, 2'b00, 0, 2'b11, 2'b11, 32'd0, 32'hABC, 32'hDEF, '0, -1, 0, 0, d);
    checks++;
    if (d != 1) begin
      errors++; $display("FAIL zero_cnt_lat got=%0d exp=1", d);
    end
  endtask

  task automatic test_stall;
    int d;
    run_op(1, 2'b00, 0, 2'b01, 2'b11, 32'd3, 32'h40, 32'h80, '0, 1, 2, 0, d);
    checks++;
    if (d != 6) begin
      errors++; $display("FAIL stall_lat got=%0d exp=6", d);
    end
  endtask

  task automatic test_repe_repne;
    int d;
    run_op(1, 2'b01, 0, 2'b00, 2'b11, 32'd5, 32'h300, 32'h600, 64'h1, -1, 0, 0, d);
    checks++;
    if (cnt_final !== 32'd3) begin
      errors++; $display("FAIL repe_cnt got=%0d exp=3", cnt_final);
    end
    run_op(1, 2'b10, 0, 2'b00, 2'b11, 32'd5, 32'h300, 32'h600, 64'h1, -1, 0, 0, d);
    checks++;
    if (cnt_final !== 32'd4) begin
      errors++; $display("FAIL repne_cnt got=%0d exp=4", cnt_final);
    end
  endtask

  task automatic test_nonrep;
    int d;
    run_op(0, 2'b01, 1, 2'b11, 2'b10, 32'd9, 32'h10, 32'h1000, '0, -1, 0, 0, d);
    checks++;
    if (d != 2) begin
      errors++; $display("FAIL nonrep_lat got=%0d exp=2", d);
    end
  endtask

  task automatic test_wrap;
    int d;
    run_op(1, 2'b00, 0, 2'b00, 2'b01, 32'd2, 32'hFFFF_FFFF, 32'h77, '0, -1, 0, 0, d);
  endtask

  task automatic test_random;
    int d;
    for (int t = 0; t < 40; t++) begin
      run_op(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
             2'($urandom), 32'($urandom_range(0, 6)), $urandom, $urandom,
             {$urandom, $urandom}, -1, 0, 1, d);
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    valid_in = 1'b1; is_rep_in = 1'b1; rep_mode = 2'b00; df_in = 1'b0;
    opsize_in = 2'b00; ch_en = 2'b11; cnt_in = 32'd2;
    addr_in = {32'h10, 32'hFFFF_FFFF};
    downstream_stall = 1'b0; zf_valid = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (iter_valid !== 1'b1 || addr_out[31:0] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mid_it0 got=%b %h exp=1 ffffffff", iter_valid, addr_out[31:0]);
    end
    @(negedge clk);
    checks++;
    if (iter_valid !== 1'b1 || addr_out[31:0] !== 32'h0 || cnt_out !== 32'd1) begin
      errors++; $display("FAIL mid_it1 got=%b %h %h exp=1 0 1", iter_valid, addr_out[31:0], cnt_out);
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({iter_valid, stall_up, done, addr_out, cnt_out, cnt_final, addr_final} !== '0) begin
      errors++; $display("FAIL mid_reset got=%b%b%b %h %h exp=0", iter_valid, stall_up, done, addr_out, addr_final);
    end
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || stall_up !== 1'b0) begin
        errors++; $display("FAIL mid_nodone got=%b%b exp=00", done, stall_up);
      end
    end
  endtask

  initial begin
    clr = 1'b0; valid_in = 1'b0; is_rep_in = 1'b0; rep_mode = 2'b00;
    df_in = 1'b0; opsize_in = 2'b00; ch_en = 2'b00; cnt_in = '0;
    addr_in = '0; downstream_stall = 1'b0; zf_in = 1'b0; zf_valid = 1'b0;
    test_reset;
    test_rep_basic;
    test_df_dec;
    test_zero_count;
    test_stall;
    test_repe_repne;
    test_nonrep;
    test_wrap;
    test_random;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
